// File: rtl/mmc_cmd_framer_if.sv
// Byte-stream bundle between the MMC edge-detect stage, the command framer
// and the FX2 FIFO4 writer.
//
// Handshake: sample_strobe is a one-cycle qualifier for sample_cmd with no
// back-pressure. On the output side a byte transfers on every FIFO_clk edge
// where out_valid && out_ready are both high. out_data is stable while
// out_valid is high and out_ready is low. out_valid never depends on out_ready.
interface mmc_cmd_framer_if;
    logic       sample_strobe;
    logic       sample_cmd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Environment side: drives the MMC samples and the consumer ready.
    modport master (
        output sample_strobe,
        output sample_cmd,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    // Framer side.
    modport slave (
        input  sample_strobe,
        input  sample_cmd,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/mmc_cmd_framer.sv
// MMC CMD-line framer. It assembles 48-bit command/response frames from
// strobed CMD samples and checks CRC7 and the end bit. Each frame becomes a
// 7-byte record (status + 6 frame bytes) queued in a small first-word-fall-through
// byte FIFO for the FX2 writer.
module mmc_cmd_framer #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic             FIFO_clk,
    input  logic             reset_n,
    mmc_cmd_framer_if.slave  bus,
    output logic             frame_busy,
    output logic [7:0]       drop_count,
    output logic [LW-1:0]    fifo_level,
    output logic             fsm_state     // debug: 1 while the shifter is in SHIFT
);
    localparam int AW = LW - 1;

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t       state, state_nxt;
    logic [5:0]   bitcnt, bitcnt_nxt;
    logic [47:0]  shreg, shreg_nxt;
    logic [6:0]   crc, crc_nxt;
    logic         done_nxt, frame_done;

    logic [55:0]  hold;
    logic [2:0]   emit_cnt;
    logic [4:0]   seq;
    logic         sticky;
    logic         crc_ok, end_ok, has_room;
    logic         push, pop;
    logic [7:0]   push_data;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Shifter state, bit count, frame and CRC registers.
    always_ff @(posedge FIFO_clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bitcnt     <= 6'd0;
            shreg      <= 48'd0;
            crc        <= 7'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            crc        <= crc_nxt;
            frame_done <= done_nxt;
        end
    end

    // Next-state logic: advance only on a strobe; the CRC covers the first 40 bits.
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        crc_nxt    = crc;
        done_nxt   = 1'b0;
        if (bus.sample_strobe) begin
            case (state)
                S_IDLE: begin
                    if (!bus.sample_cmd) begin
                        state_nxt  = S_SHIFT;
                        bitcnt_nxt = 6'd1;
                        shreg_nxt  = 48'd0;     // start bit is a 0 in bit 0
                        crc_nxt    = 7'd0;      // a zero bit from a zero CRC stays zero
                    end
                end
                S_SHIFT: begin
                    shreg_nxt  = {shreg[46:0], bus.sample_cmd};
                    bitcnt_nxt = bitcnt + 6'd1;
                    if (bitcnt < 6'd40) begin
                        crc_nxt = crc7_step(crc, bus.sample_cmd);
                    end
                    if (bitcnt == 6'd47) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign frame_busy = (state == S_SHIFT);
    assign fsm_state  = (state == S_SHIFT);

    assign crc_ok    = (crc == shreg[7:1]);
    assign end_ok    = shreg[0];
    assign has_room  = (fifo_level <= LW'(DEPTH - 7));
    assign push      = (emit_cnt != 3'd0);
    assign push_data = hold[55:48];

    // Capture decision after frame_done, then stream the hold register out one byte per cycle.
    always_ff @(posedge FIFO_clk) begin
        if (!reset_n) begin
            hold       <= 56'd0;
            emit_cnt   <= 3'd0;
            seq        <= 5'd0;
            sticky     <= 1'b0;
            drop_count <= 8'd0;
        end else if (frame_done) begin
            if (has_room) begin
                hold     <= {crc_ok, end_ok, sticky, seq, shreg};
                emit_cnt <= 3'd7;
                seq      <= seq + 5'd1;
                sticky   <= 1'b0;
            end else begin
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
                sticky <= 1'b1;
            end
        end else if (push) begin
            hold     <= {hold[47:0], 8'h00};
            emit_cnt <= emit_cnt - 3'd1;
        end
    end

    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (fifo_level != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 8'h00;

    // FIFO storage write port.
    always_ff @(posedge FIFO_clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge FIFO_clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Space is reserved before a record starts, so a push into a full FIFO is a design bug.
    a_no_overflow: assert property (@(posedge FIFO_clk) disable iff (!reset_n)
        !(push && fifo_level == LW'(DEPTH)));

endmodule

// File: tb/tb_mmc_cmd_framer.sv
// Bench for mmc_cmd_framer: directed CMD frames with a queue-based reference
// of the record stream and output FIFO, checked every cycle.
module tb_mmc_cmd_framer;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam logic [47:0] CMD0     = 48'h40_00_00_00_00_95;
    localparam logic [47:0] CMD8     = 48'h48_00_00_01_AA_87;
    localparam logic [47:0] CMD8_BAD = 48'h48_00_00_01_AA_85;

    // ---------------- clock / reset ----------------
    logic          FIFO_clk = 1'b0;
    logic          reset_n  = 1'b0;
    logic          frame_busy, fsm_state;
    logic [7:0]    drop_count;
    logic [LW-1:0] fifo_level;

    mmc_cmd_framer_if bus();

    mmc_cmd_framer #(.DEPTH(DEPTH), .LW(LW)) dut (
        .FIFO_clk   (FIFO_clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .frame_busy (frame_busy),
        .drop_count (drop_count),
        .fifo_level (fifo_level),
        .fsm_state  (fsm_state)
    );

    always #5 FIFO_clk = ~FIFO_clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;
    logic ready_lvl = 1'b1;
    logic toggle_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference CRC7 over the 40 covered bits, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  exp_q[$];    // bytes that must currently sit in the FIFO, head first
    logic [7:0]  emit_q[$];   // record bytes decided but not yet entered
    logic [7:0]  pop_log[$];  // every byte consumed, in order
    logic [47:0] sent_fr [64];
    int          frames_sent = 0;
    int          frames_seen = 0;
    int          wait_cnt = 0;
    logic [4:0]  seq_m = 5'd0;
    logic        sticky_m = 1'b0;
    int          drop_m = 0;

    function automatic void model_frame(input logic [47:0] f);
        logic c_ok, e_ok;
        c_ok = (crc7(f[47:8]) == f[7:1]);
        e_ok = f[0];
        if (DEPTH - exp_q.size() >= 7) begin
            emit_q.push_back({c_ok, e_ok, sticky_m, seq_m});
            for (int k = 5; k >= 0; k--) emit_q.push_back(f[k*8 +: 8]);
            seq_m    = seq_m + 5'd1;
            sticky_m = 1'b0;
            wait_cnt = 1;
        end else begin
            if (drop_m < 255) drop_m++;
            sticky_m = 1'b1;
        end
    endfunction

    // Compare on the falling edge, then step the model across the next rising edge.
    initial begin
        forever begin
            @(negedge FIFO_clk);
            if (chk_en) begin
                chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
                chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                chk("drop_count", 32'(drop_count), 32'(drop_m));
                if (!reset_n) begin
                    exp_q.delete();
                    emit_q.delete();
                    wait_cnt    = 0;
                    seq_m       = 5'd0;
                    sticky_m    = 1'b0;
                    drop_m      = 0;
                    frames_seen = frames_sent;
                end else begin
                    if (frames_seen < frames_sent) begin
                        model_frame(sent_fr[frames_seen]);
                        frames_seen++;
                    end
                    if (exp_q.size() != 0 && bus.out_ready) pop_log.push_back(exp_q.pop_front());
                    if (wait_cnt > 0) wait_cnt--;
                    else if (emit_q.size() != 0) exp_q.push_back(emit_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge FIFO_clk);
            #1;
            bus.out_ready = toggle_en ? ~bus.out_ready : ready_lvl;
        end
    end

    task automatic send_bit(input logic b);
        @(posedge FIFO_clk); #1;
        bus.sample_strobe = 1'b1;
        bus.sample_cmd    = b;
        @(posedge FIFO_clk); #1;
        bus.sample_strobe = 1'b0;
    endtask

    // Strobe period is gap+2 cycles; the frame is handed to the model right after its last edge.
    task automatic send_frame(input logic [47:0] f, input int gap);
        for (int i = 47; i >= 0; i--) begin
            send_bit(f[i]);
            if (i == 0) begin
                sent_fr[frames_sent] = f;
                frames_sent++;
            end
            repeat (gap) @(posedge FIFO_clk);
        end
    endtask

    task automatic do_reset();
        @(posedge FIFO_clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge FIFO_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_out_valid"},  32'(bus.out_valid), 32'd0);
        chk({nm, "_out_data"},   32'(bus.out_data),  32'd0);
        chk({nm, "_frame_busy"}, 32'(frame_busy),    32'd0);
        chk({nm, "_drop_count"}, 32'(drop_count),    32'd0);
        chk({nm, "_fifo_level"}, 32'(fifo_level),    32'd0);
    endtask

    task automatic check_rec(input string nm, input int base, input logic [55:0] e);
        for (int k = 0; k < 7; k++) begin
            if (base + k < pop_log.size())
                chk(nm, 32'(pop_log[base+k]), 32'(e[55-8*k -: 8]));
            else
                chk({nm, "_missing"}, 32'(pop_log.size()), 32'(base + k + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int b;
        bus.sample_strobe = 1'b0;
        bus.sample_cmd    = 1'b1;
        reset_n = 1'b0;
        @(posedge FIFO_clk); #1;
        chk_en = 1'b1;
        @(posedge FIFO_clk); #1;
        reset_n = 1'b1;
        check_reset_vals("reset");

        // Pin the reference CRC against known MMC frames.
        chk("crc_pin_cmd0", 32'(crc7(40'h40_00_00_00_00)), 32'h4A);
        chk("crc_pin_cmd8", 32'(crc7(40'h48_00_00_01_AA)), 32'h43);

        // CMD0, strobe every 4 cycles, consumer always ready.
        b = pop_log.size();
        send_frame(CMD0, 2);
        repeat (20) @(posedge FIFO_clk);
        check_rec("t1_cmd0", b, {8'hC0, CMD0});
        chk("t1_busy_after", 32'(frame_busy), 32'd0);

        // CMD8 with good CRC, then with a corrupted CRC.
        b = pop_log.size();
        send_frame(CMD8, 2);
        send_frame(CMD8_BAD, 2);
        repeat (20) @(posedge FIFO_clk);
        check_rec("t2_cmd8", b, {8'hC1, CMD8});
        check_rec("t2_cmd8_bad", b + 7, {8'h42, CMD8_BAD});

        // Back-pressure: two records fit, the third is dropped.
        do_reset();
        check_reset_vals("t3_reset");
        ready_lvl = 1'b0;
        repeat (3) @(posedge FIFO_clk);
        b = pop_log.size();
        send_frame(CMD0, 0);
        send_frame(CMD0, 0);
        send_frame(CMD0, 0);
        repeat (12) @(posedge FIFO_clk);
        chk("t3_level_full", 32'(fifo_level), 32'd14);
        chk("t3_drop_count", 32'(drop_count), 32'd1);
        ready_lvl = 1'b1;
        repeat (25) @(posedge FIFO_clk);
        check_rec("t3_rec0", b, {8'hC0, CMD0});
        check_rec("t3_rec1", b + 7, {8'hC1, CMD0});
        send_frame(CMD0, 2);
        repeat (15) @(posedge FIFO_clk);
        send_frame(CMD0, 2);
        repeat (20) @(posedge FIFO_clk);
        check_rec("t3_sticky", b + 14, {8'hE2, CMD0});
        check_rec("t3_cleared", b + 21, {8'hC3, CMD0});

        // Idle line: ones never start a frame, the first zero does.
        for (int i = 0; i < 100; i++) begin
            send_bit(1'b1);
            chk("t4_idle_busy", 32'(frame_busy), 32'd0);
        end
        b = pop_log.size();
        for (int i = 47; i >= 0; i--) begin
            send_bit(CMD0[i]);
            if (i == 47) chk("t4_start_busy", 32'(frame_busy), 32'd1);
            if (i == 0) begin
                sent_fr[frames_sent] = CMD0;
                frames_sent++;
            end
        end
        repeat (20) @(posedge FIFO_clk);
        check_rec("t4_cmd0", b, {8'hC4, CMD0});

        // Reset in the middle of a frame, then a clean frame restarts seq at 0.
        for (int i = 47; i >= 28; i--) send_bit(CMD0[i]);
        chk("t5_busy_mid", 32'(frame_busy), 32'd1);
        do_reset();
        check_reset_vals("t5_reset");
        b = pop_log.size();
        send_frame(CMD0, 2);
        repeat (20) @(posedge FIFO_clk);
        check_rec("t5_cmd0", b, {8'hC0, CMD0});

        // Consumer toggling ready every cycle while the record streams in.
        toggle_en = 1'b1;
        b = pop_log.size();
        send_frame(CMD8, 2);
        repeat (30) @(posedge FIFO_clk);
        check_rec("t6_toggle", b, {8'hC1, CMD8});
        toggle_en = 1'b0;
        repeat (5) @(posedge FIFO_clk);
        chk("t6_drained", 32'(fifo_level), 32'd0);
        chk("t6_total_bytes", 32'(pop_log.size()), 32'(b + 7));

        repeat (5) @(posedge FIFO_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
